// File: rtl/nrzi_rx_unstuff_deser.sv
// nrzi_rx_unstuff_deser: USB receive path - NRZI decode, SYNC hunt, bit unstuffing, LSB-first deserialisation.
// Ports:
//   Nrzi_Rx_Clk / Nrzi_Rx_Rst     clock, synchronous active-high reset
//   Nrzi_Rx_Bit_In                raw NRZI line bit, qualified by Nrzi_Rx_Bit_Valid
//   Nrzi_Rx_Bit_Valid             one-cycle strobe per line bit
//   Nrzi_Rx_Se0                   line in SE0, qualified by Nrzi_Rx_Bit_Valid
//   Nrzi_Rx_Data_Out/_Data_Valid  assembled word (first bit in bit 0) and its one-cycle pulse
//   Nrzi_Rx_Eop/_Eop_Bits         EOP pulse and leftover bit count of the partial word
//   Nrzi_Rx_Stuff_Err             pulse on a stuff violation
//   Nrzi_Rx_Active                high while receiving payload
//   Nrzi_Rx_Err_Count             saturating stuff-error count, only with NRZI_RX_ERR_COUNT_EN defined
module nrzi_rx_unstuff_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int STUFF_LIMIT = 6,
  parameter int SYNC_BITS = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                          Nrzi_Rx_Clk,
  input  logic                          Nrzi_Rx_Rst,
  input  logic                          Nrzi_Rx_Bit_In,
  input  logic                          Nrzi_Rx_Bit_Valid,
  input  logic                          Nrzi_Rx_Se0,
  output logic [DATA_WIDTH-1:0]         Nrzi_Rx_Data_Out,
  output logic                          Nrzi_Rx_Data_Valid,
  output logic                          Nrzi_Rx_Eop,
  output logic [$clog2(DATA_WIDTH)-1:0] Nrzi_Rx_Eop_Bits,
  output logic                          Nrzi_Rx_Stuff_Err,
  output logic                          Nrzi_Rx_Active
`ifdef NRZI_RX_ERR_COUNT_EN
  ,
  output logic [7:0]                    Nrzi_Rx_Err_Count
`endif
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [SYNC_BITS-1:0] SYNC_PAT = SYNC_BITS'(1);
  typedef enum logic [1:0] {IDLE, DATA, ERROR} state_t;
  state_t state, state_nx;
  logic prev_line, prev_nx, dec;
  logic [SYNC_BITS-1:0] hunt, hunt_nx, hunt_sh;
  logic [OW-1:0] ones_cnt, ones_nx;
  logic [BW-1:0] bit_cnt, bit_nx, eop_bits_nx;
  logic [DATA_WIDTH-1:0] word, word_nx, data_nx;
  logic dv_nx, eop_nx, err_nx;
  assign dec = ~(Nrzi_Rx_Bit_In ^ prev_line);
  assign hunt_sh = {hunt[SYNC_BITS-2:0], dec};
  // An empty hunt register holds all 1s so that idle J bits (decoded 1s) can never complete a SYNC.
  always_comb begin
    state_nx = state;
    prev_nx = prev_line;
    hunt_nx = hunt;
    ones_nx = ones_cnt;
    bit_nx = bit_cnt;
    word_nx = word;
    data_nx = Nrzi_Rx_Data_Out;
    eop_bits_nx = Nrzi_Rx_Eop_Bits;
    dv_nx = 1'b0;
    eop_nx = 1'b0;
    err_nx = 1'b0;
    if (Nrzi_Rx_Bit_Valid) begin
      prev_nx = Nrzi_Rx_Se0 ? IDLE_LEVEL : Nrzi_Rx_Bit_In;
      case (state)
        IDLE: begin
          if (Nrzi_Rx_Se0) hunt_nx = '1;
          else if (hunt_sh == SYNC_PAT) begin
            state_nx = DATA;
            hunt_nx = '1;
            ones_nx = OW'(1);
            bit_nx = '0;
          end else hunt_nx = hunt_sh;
        end
        DATA: begin
          if (Nrzi_Rx_Se0) begin
            eop_nx = 1'b1;
            eop_bits_nx = bit_cnt;
            state_nx = IDLE;
          end else if (ones_cnt == OW'(STUFF_LIMIT)) begin
            // Bit after STUFF_LIMIT ones must be a stuffed 0; a 1 is a violation.
            err_nx = dec;
            state_nx = dec ? ERROR : DATA;
            ones_nx = '0;
          end else begin
            word_nx[bit_cnt] = dec;
            ones_nx = dec ? ones_cnt + 1'b1 : '0;
            dv_nx = (bit_cnt == BW'(DATA_WIDTH - 1));
            data_nx = dv_nx ? word_nx : Nrzi_Rx_Data_Out;
            bit_nx = dv_nx ? '0 : bit_cnt + 1'b1;
          end
        end
        default: state_nx = Nrzi_Rx_Se0 ? IDLE : ERROR;
      endcase
    end
  end
  always_ff @(posedge Nrzi_Rx_Clk) begin
    if (Nrzi_Rx_Rst) begin
      state <= IDLE;
      prev_line <= IDLE_LEVEL;
      hunt <= '1;
      ones_cnt <= '0;
      bit_cnt <= '0;
      word <= '0;
      Nrzi_Rx_Data_Out <= '0;
      Nrzi_Rx_Data_Valid <= 1'b0;
      Nrzi_Rx_Eop <= 1'b0;
      Nrzi_Rx_Eop_Bits <= '0;
      Nrzi_Rx_Stuff_Err <= 1'b0;
      Nrzi_Rx_Active <= 1'b0;
    end else begin
      state <= state_nx;
      prev_line <= prev_nx;
      hunt <= hunt_nx;
      ones_cnt <= ones_nx;
      bit_cnt <= bit_nx;
      word <= word_nx;
      Nrzi_Rx_Data_Out <= data_nx;
      Nrzi_Rx_Data_Valid <= dv_nx;
      Nrzi_Rx_Eop <= eop_nx;
      Nrzi_Rx_Eop_Bits <= eop_bits_nx;
      Nrzi_Rx_Stuff_Err <= err_nx;
      Nrzi_Rx_Active <= (state_nx == DATA);
    end
  end
`ifdef NRZI_RX_ERR_COUNT_EN
  always_ff @(posedge Nrzi_Rx_Clk) begin
    if (Nrzi_Rx_Rst) Nrzi_Rx_Err_Count <= '0;
    else if (err_nx && Nrzi_Rx_Err_Count != 8'hFF) Nrzi_Rx_Err_Count <= Nrzi_Rx_Err_Count + 1'b1;
  end
`else
`endif
endmodule

// File: tb/tb_nrzi_rx_unstuff_deser.sv
// tb_nrzi_rx_unstuff_deser: scoreboard bench for nrzi_rx_unstuff_deser with default parameters.
module tb_nrzi_rx_unstuff_deser;
  localparam int DW = 8;
  localparam int SL = 6;
  localparam int SB = 8;
  logic clk = 1'b0, rst = 1'b1, bit_in = 1'b1, valid = 1'b0, se0 = 1'b0;
  logic [DW-1:0] dout;
  logic [$clog2(DW)-1:0] eop_bits;
  logic dv, eop, serr, active;
`ifdef NRZI_RX_ERR_COUNT_EN
  logic [7:0] err_count;
`endif
  nrzi_rx_unstuff_deser dut (
    .Nrzi_Rx_Clk(clk),
    .Nrzi_Rx_Rst(rst),
    .Nrzi_Rx_Bit_In(bit_in),
    .Nrzi_Rx_Bit_Valid(valid),
    .Nrzi_Rx_Se0(se0),
    .Nrzi_Rx_Data_Out(dout),
    .Nrzi_Rx_Data_Valid(dv),
    .Nrzi_Rx_Eop(eop),
    .Nrzi_Rx_Eop_Bits(eop_bits),
    .Nrzi_Rx_Stuff_Err(serr),
    .Nrzi_Rx_Active(active)
`ifdef NRZI_RX_ERR_COUNT_EN
    ,
    .Nrzi_Rx_Err_Count(err_count)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, dv_seen = 0, eop_seen = 0, err_seen = 0;
  logic line = 1'b1;
  logic [DW-1:0] exp_q[$];
  int eop_q[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (dv) begin
      dv_seen++;
      if (exp_q.size() == 0) check("dv_unexpected", 1, 0);
      else check("data_out", dout, exp_q.pop_front());
    end
    if (eop) begin
      eop_seen++;
      if (eop_q.size() == 0) check("eop_unexpected", 1, 0);
      else check("eop_bits", eop_bits, eop_q.pop_front());
    end
    if (serr) err_seen++;
  end
  task automatic strobe(input logic b, input logic s);
    bit_in = b;
    se0 = s;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    se0 = 1'b0;
  endtask
  task automatic send_dec(input logic d);
    if (!d) line = ~line;
    strobe(line, 1'b0);
  endtask
  task automatic send_se0;
    strobe(1'b0, 1'b1);
    line = 1'b1;
  endtask
  task automatic send_sync;
    for (int i = 0; i < SB - 1; i++) send_dec(1'b0);
    send_dec(1'b1);
  endtask
  task automatic send_word(input logic [DW-1:0] w, inout int ones);
    for (int i = 0; i < DW; i++) begin
      if (ones == SL) begin
        send_dec(1'b0);
        ones = 0;
      end
      send_dec(w[i]);
      ones = w[i] ? ones + 1 : 0;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [DW-1:0] a5;
    logic [DW-1:0] gw;
    int ones, dv_before;
    a5 = 8'hA5;
    gw = 8'hC3;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_dv", dv, 0);
    check("rst_eop", eop, 0);
    check("rst_eop_bits", eop_bits, 0);
    check("rst_serr", serr, 0);
    check("rst_active", active, 0);
`ifdef NRZI_RX_ERR_COUNT_EN
    check("rst_err_count", err_count, 0);
`endif
    for (int i = 0; i < 12; i++) strobe(1'b1, 1'b0);
    @(negedge clk);
    check("idle_active", active, 0);
    check("idle_no_dv", dv_seen, 0);
    // SYNC then 0xA5, then EOP
    send_sync;
    @(negedge clk);
    check("sync_active", active, 1);
    exp_q.push_back(a5);
    for (int i = 0; i < DW; i++) send_dec(a5[i]);
    @(negedge clk);
    check("a5_latency", dv, 1);
    eop_q.push_back(0);
    send_se0;
    @(negedge clk);
    check("a5_eop", eop, 1);
    check("a5_active_fall", active, 0);
    // 0xFF with a stuffed 0 after the sixth 1 (SYNC's final 1 counts)
    send_sync;
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 5; i++) send_dec(1'b1);
    send_dec(1'b0);
    for (int i = 0; i < 3; i++) send_dec(1'b1);
    @(negedge clk);
    check("ff_dv", dv, 1);
    eop_q.push_back(0);
    send_se0;
    // same stream with the stuff bit violated
    send_sync;
    dv_before = dv_seen;
    for (int i = 0; i < 5; i++) send_dec(1'b1);
    send_dec(1'b1);
    @(negedge clk);
    check("stuff_err", serr, 1);
    check("err_active", active, 0);
`ifdef NRZI_RX_ERR_COUNT_EN
    check("err_count", err_count, 1);
`endif
    for (int i = 0; i < 10; i++) send_dec(i[0]);
    @(negedge clk);
    check("err_hold_active", active, 0);
    check("err_no_dv", dv_seen, dv_before);
    send_se0;
    @(negedge clk);
    check("err_no_eop", eop, 0);
    send_sync;
    @(negedge clk);
    check("resync_active", active, 1);
    ones = 1;
    exp_q.push_back(8'h5A);
    send_word(8'h5A, ones);
    eop_q.push_back(0);
    send_se0;
    // partial word EOP
    send_sync;
    dv_before = dv_seen;
    send_dec(1'b1);
    send_dec(1'b0);
    send_dec(1'b1);
    eop_q.push_back(3);
    send_se0;
    @(negedge clk);
    check("partial_eop", eop, 1);
    check("partial_no_dv", dv_seen, dv_before);
    // SE0 arriving when a stuff bit is due: EOP, no error
    send_sync;
    for (int i = 0; i < 5; i++) send_dec(1'b1);
    eop_q.push_back(5);
    send_se0;
    @(negedge clk);
    check("se0_stuff_eop", eop, 1);
    check("se0_stuff_no_err", serr, 0);
    // gaps of 5 clocks between payload bits
    send_sync;
    exp_q.push_back(gw);
    for (int i = 0; i < DW; i++) begin
      send_dec(gw[i]);
      if (i < DW - 1) idle(5);
    end
    @(negedge clk);
    check("gap_dv", dv, 1);
    eop_q.push_back(0);
    send_se0;
    // reset mid-word
    send_sync;
    send_dec(1'b1);
    send_dec(1'b1);
    send_dec(1'b0);
    send_dec(1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    line = 1'b1;
    @(negedge clk);
    check("midrst_active", active, 0);
    check("midrst_dout", dout, 0);
    check("midrst_dv", dv, 0);
    check("midrst_eop", eop, 0);
    check("midrst_serr", serr, 0);
    check("midrst_eop_bits", eop_bits, 0);
    // random multi-word packets, first word forces stuffing
    for (int p = 0; p < 3; p++) begin
      send_sync;
      ones = 1;
      for (int k = 0; k < 3; k++) begin
        logic [DW-1:0] w;
        w = (k == 0) ? 8'hFF : DW'($urandom);
        exp_q.push_back(w);
        send_word(w, ones);
      end
      eop_q.push_back(0);
      send_se0;
      idle(3);
    end
    idle(2);
    @(negedge clk);
    check("words_left", exp_q.size(), 0);
    check("eops_left", eop_q.size(), 0);
    check("err_pulses", err_seen, 1);
    check("eop_total", eop_seen, 9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nrzi_rx_unstuff_deser.md
Name: nrzi_rx_unstuff_deser

Overview:
Parametrised USB receive-path block and next generation of the single-bit NRZI decoder.
- Decodes NRZI line bits, hunts for SYNC, strips stuffed bits and deserialises payload LSB-first into DATA_WIDTH-bit words.
- Flags EOP (SE0) and bit-stuff violations.
- Sits between the line sampler/DPLL, which supplies the bit strobes, and the packet decoder.

Parameters:
DATA_WIDTH, 8, payload word width in bits (>=2)
STUFF_LIMIT, 6, consecutive decoded 1s after which the next bit is a stuff bit (>=2)
SYNC_BITS, 8, SYNC pattern length: SYNC_BITS-1 decoded 0s then one 1 (4..16)
IDLE_LEVEL, 1, line level of idle/J state; reload value of previous-line register

Ports:
Nrzi_Rx_Clk  in  1  clock
Nrzi_Rx_Rst  in  1  synchronous reset, active-high
Nrzi_Rx_Bit_In  in  1  raw NRZI line bit, sampled only when Nrzi_Rx_Bit_Valid=1
Nrzi_Rx_Bit_Valid  in  1  one-cycle strobe per line bit
Nrzi_Rx_Se0  in  1  line in SE0, qualified by Nrzi_Rx_Bit_Valid
Nrzi_Rx_Data_Out  out  DATA_WIDTH  assembled word; first received bit in bit 0
Nrzi_Rx_Data_Valid  out  1  one-cycle pulse, Data_Out valid
Nrzi_Rx_Eop  out  1  one-cycle pulse, SE0 seen while in DATA
Nrzi_Rx_Eop_Bits  out  $clog2(DATA_WIDTH)  leftover bits in partial word at EOP (0 = byte-aligned)
Nrzi_Rx_Stuff_Err  out  1  one-cycle pulse on stuff violation
Nrzi_Rx_Active  out  1  high in DATA state

Behaviour:
- Decode: decoded bit = ~(Bit_In ^ prev_line). No transition = 1.
- On each valid non-SE0 bit: prev_line <= Bit_In.
- On valid SE0: prev_line <= IDLE_LEVEL.
- All outputs registered. Every output is 0 on reset, except Data_Out = 0 and Eop_Bits = 0.
- Reset also forces state IDLE, prev_line = IDLE_LEVEL, and clears the hunt register, ones_cnt and bit_cnt.
- Reset mid-packet discards any partial word silently; no Eop or Stuff_Err pulse is generated.
- Bit_Valid = 0: all state holds, pulses deassert.
- States:
  - IDLE: shift decoded bits into a SYNC_BITS hunt register. On match -> DATA, ones_cnt = 1 (SYNC final 1 counts toward stuffing), bit_cnt = 0. SE0 clears the hunt register and stays in IDLE.
  - DATA, on valid non-SE0 bit:
    - If ones_cnt == STUFF_LIMIT, the bit is a stuff bit. Decoded 0: discard it, ones_cnt = 0. Decoded 1: Stuff_Err pulse -> ERROR, partial word dropped.
    - Otherwise shift the decoded bit into the word at position bit_cnt. ones_cnt = (bit ? ones_cnt+1 : 0). bit_cnt increments.
    - When bit_cnt reaches DATA_WIDTH-1 and a payload bit is accepted: Data_Out <= word, Data_Valid pulses next cycle (latency 1 clock from the strobe carrying the last bit), bit_cnt wraps to 0.
  - DATA, on valid SE0: Eop pulse, Eop_Bits <= bit_cnt, no Data_Valid, -> IDLE. Partial word is not emitted.
  - ERROR: ignore bits until a valid SE0, then -> IDLE with no Eop pulse. Active = 0.
- Simultaneous cases:
  - A stuff bit that is due at the same time as SE0: SE0 wins (EOP, no error).
  - SE0 with Bit_Valid = 0 is ignored.
- Data_Out holds its value between Data_Valid pulses.

Optional Feature:
Macro NRZI_RX_ERR_COUNT_EN.
- Defined: adds output port Nrzi_Rx_Err_Count (8 bits). It increments on every Stuff_Err pulse, saturates at 255 and is cleared only by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
Bench NRZI-encodes decoded streams from prev_line = 1. Default parameters unless stated.
- Reset/idle: assert Rst for 2 clocks, then idle J bits -> all outputs 0, Active = 0, no Data_Valid.
- SYNC + word: decoded 0000_0001, then bits 1,0,1,0,0,1,0,1, then SE0 -> one Data_Valid with Data_Out = 0xA5 exactly 1 clock after the 8th payload strobe, then Eop with Eop_Bits = 0 and Active falling.
- Stuffing: SYNC, then payload 0xFF sent as 1,1,1,1,1,0(stuff),1,1,1 -> Data_Out = 0xFF. The stuffed 0 is absent from the data.
  - Same stream with the stuff bit = 1 -> Stuff_Err pulse, no Data_Valid, ERROR held until SE0, then IDLE accepts a new SYNC.
  - With the macro defined, Err_Count goes 0 -> 1.
- Partial EOP: SYNC, 3 payload bits, SE0 -> Eop pulse with Eop_Bits = 3, no Data_Valid.
- Gaps and reset: Bit_Valid low for 5 clocks between payload bits -> same word result.
  - Rst asserted mid-word -> IDLE with all outputs 0 next clock.
  - The next full packet decodes correctly.
